rf_dm_alu_multicycle: RTL
=========================

Name: rf_dm_alu_multicycle

Overview:
- Parametrised, multi-cycle successor to the single-cycle register-file / data-memory / ALU datapath.
- Accepts one decoded instruction per start/done handshake and steps it through operand read, execute, optional memory access and write-back under an FSM.
- Registered ALU result and zero flag are exposed for the future control unit and the bench.
- Adds generic widths, a reset-cleared register file, shift ops and explicit busy/done handshaking.

Parameters:
DATA_W, 32, datapath and register width (minimum 16)
REG_AW, 5, register address width; register file has 2**REG_AW entries
MEM_AW, 6, data memory word-address width; memory has 2**MEM_AW words

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  instruction valid; sampled only in IDLE
rs  in  REG_AW  source register A
rt  in  REG_AW  source register B / I-type destination
rd  in  REG_AW  R-type destination
se_in  in  16  immediate, sign-extended to DATA_W
func_code  in  4  function field used when alu_op=10
alu_op  in  2  00 add, 01 sub, 10 decode func_code, 11 reserved (result 0)
reg_sel  in  1  1: write rd, 0: write rt
alu_sel  in  1  1: B operand = extended immediate, 0: B operand = R[rt]
mem_write  in  1  store R[rt] to memory
mem_read  in  1  load from memory
mem_to_reg_sel  in  1  1: write-back memory data, 0: write-back ALU result
reg_write  in  1  enable register write-back
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in WB state
alu_out  out  DATA_W  registered ALU result
zero  out  1  registered, alu_out == 0
mem_rdata  out  DATA_W  registered memory read data

Behaviour:
- Reset: state=IDLE; busy=0, done=0, alu_out=0, zero=1, mem_rdata=0; all registers cleared to 0. Memory contents are not reset.
- Reset while busy: abandon the instruction, return to IDLE and commit no write.
- Reset has priority over start.
- IDLE: when start=1, latch every instruction input and go to READ. Inputs may change afterwards.
- While busy, start is ignored. It is not queued.
- READ: capture A=R[rs]. Capture B=R[rt] or sign-extended immediate, per alu_sel. Capture store data=R[rt].
- EXEC: compute result; register alu_out and zero.
  - Next state is MEM if mem_read or mem_write, else WB.
- ALU functions: add/sub are modulo 2**DATA_W.
  - func_code 0000 add, 0010 sub, 0100 and, 0101 or.
  - 1010 slt: signed compare, result 1/0.
  - 1000 sll A by B[4:0]; 1001 srl (logical) A by B[4:0].
  - Any other code gives result 0.
- MEM: word address = alu_out[MEM_AW-1:0]; addresses wrap modulo depth.
  - If mem_read, register mem_rdata from the old contents (read-before-write when both are set).
  - If mem_write, write store data. Go to WB.
- WB: done=1 for this cycle only.
  - If reg_write, write destination ← (mem_to_reg_sel ? mem_rdata : alu_out) on this cycle's edge. Destination is rd if reg_sel=1, else rt.
  - Writes to register 0 are discarded; register 0 always reads 0.
  - Next state IDLE.
- Latency: start edge → done is 4 cycles for non-memory instructions and 5 for memory instructions.
- A new instruction accepted on the cycle after done sees the written-back value.
- alu_out, zero and mem_rdata hold their values until overwritten by a later instruction.

Test Plan:
1. Reset, then start an addi-like op: rs=0, se_in=0x0014, alu_sel=1, alu_op=00, reg_sel=1, rd=5, reg_write=1 → done 4 cycles after start, alu_out=0x14, zero=0, R5=0x14. Repeat with rd=10, se_in=0x0028 → R10=0x28.
2. R-type with rs=5, rt=10, alu_op=10, rd=3 → func 0000 gives 0x3C; 0010 gives 0xFFFFFFEC; 0100 gives 0x0; 0101 gives 0x3C; 1010 gives 1. The and case must show zero=1.
3. Store then load: store rs=0, rt=10, se_in=2, mem_write=1 → memory word 2 = 0x28, done at cycle 5. Load rs=0, se_in=2, mem_read=1, mem_to_reg_sel=1, reg_sel=0, rt=7 → R7=0x28. Repeat with se_in=66 (64-word memory) → same word, showing address wrap.
4. Write to register 0: an add with rd=0 and se_in=0x55 → alu_out=0x55, but a later read of R0 returns 0. Pulsing start while busy has no effect and produces exactly one done.
5. Shift and unknown codes: A=0x14, B=2 → func 1000 gives 0x50, 1001 gives 0x5. func 1111 gives 0 with zero=1. alu_op=11 gives 0.
6. Assert rst during EXEC of a reg_write instruction → IDLE next cycle, busy=0, destination register still 0, no done pulse.

Source files
------------

// File: rtl/rf_dm_alu_multicycle.sv
// Multi-cycle register-file / data-memory / ALU datapath.
// Takes one decoded instruction per start/done handshake: READ, EXEC, optional MEM, then WB.
module rf_dm_alu_multicycle #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [15:0]       i_se_in,
  input  logic [3:0]        i_func_code,
  input  logic [1:0]        i_alu_op,
  input  logic              i_reg_sel,
  input  logic              i_alu_sel,
  input  logic              i_mem_write,
  input  logic              i_mem_read,
  input  logic              i_mem_to_reg_sel,
  input  logic              i_reg_write,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_alu_out,
  output logic              o_zero,
  output logic [DATA_W-1:0] o_mem_rdata
);

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0010;
  localparam logic [3:0] F_AND = 4'b0100;
  localparam logic [3:0] F_OR  = 4'b0101;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRL = 4'b1001;
  localparam logic [3:0] F_SLT = 4'b1010;

  // state | meaning: IDLE wait start | READ operands | EXEC alu | MEM data memory | WB write-back
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [15:0]       r_se_in;
  logic [3:0]        r_func_code;
  logic [1:0]        r_alu_op;
  logic              r_reg_sel;
  logic              r_alu_sel;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_mem_to_reg_sel;
  logic              r_reg_write;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_st_data;
  logic [DATA_W-1:0] r_alu_out;
  logic              r_zero;
  logic [DATA_W-1:0] r_mem_rdata;

  logic [DATA_W-1:0] r_regs [2**REG_AW];
  logic [DATA_W-1:0] r_mem  [2**MEM_AW];

  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_alu_res;
  logic [MEM_AW-1:0] w_maddr;
  logic [REG_AW-1:0] w_dst;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_rf_we;
  logic              w_mem_we;

  assign w_imm_ext = DATA_W'($signed(r_se_in));
  assign w_maddr   = r_alu_out[MEM_AW-1:0];
  assign w_dst     = r_reg_sel ? r_rd : r_rt;
  assign w_wb_data = r_mem_to_reg_sel ? r_mem_rdata : r_alu_out;
  assign w_rf_we   = (r_state == S_WB) && r_reg_write && (w_dst != '0);
  // Reset wins over a pending store so an abandoned instruction commits nothing.
  assign w_mem_we  = !i_rst && (r_state == S_MEM) && r_mem_write;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b1;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_READ;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = (r_mem_read || r_mem_write) ? S_MEM : S_WB;
      S_MEM:  w_next = S_WB;
      S_WB: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    case (r_alu_op)
      2'b00: w_alu_res = r_a + r_b;
      2'b01: w_alu_res = r_a - r_b;
      2'b10: begin
        case (r_func_code)
          F_ADD: w_alu_res = r_a + r_b;
          F_SUB: w_alu_res = r_a - r_b;
          F_AND: w_alu_res = r_a & r_b;
          F_OR:  w_alu_res = r_a | r_b;
          F_SLL: w_alu_res = r_a << r_b[4:0];
          F_SRL: w_alu_res = r_a >> r_b[4:0];
          F_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
          default: w_alu_res = '0;
        endcase
      end
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rs             <= '0;
      r_rt             <= '0;
      r_rd             <= '0;
      r_se_in          <= '0;
      r_func_code      <= '0;
      r_alu_op         <= '0;
      r_reg_sel        <= 1'b0;
      r_alu_sel        <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_to_reg_sel <= 1'b0;
      r_reg_write      <= 1'b0;
      r_a              <= '0;
      r_b              <= '0;
      r_st_data        <= '0;
      r_alu_out        <= '0;
      r_zero           <= 1'b1;
      r_mem_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rs             <= i_rs;
            r_rt             <= i_rt;
            r_rd             <= i_rd;
            r_se_in          <= i_se_in;
            r_func_code      <= i_func_code;
            r_alu_op         <= i_alu_op;
            r_reg_sel        <= i_reg_sel;
            r_alu_sel        <= i_alu_sel;
            r_mem_write      <= i_mem_write;
            r_mem_read       <= i_mem_read;
            r_mem_to_reg_sel <= i_mem_to_reg_sel;
            r_reg_write      <= i_reg_write;
          end
        end
        S_READ: begin
          r_a       <= r_regs[r_rs];
          r_b       <= r_alu_sel ? w_imm_ext : r_regs[r_rt];
          r_st_data <= r_regs[r_rt];
        end
        S_EXEC: begin
          r_alu_out <= w_alu_res;
          r_zero    <= (w_alu_res == '0);
        end
        S_MEM: begin
          if (r_mem_read) r_mem_rdata <= r_mem[w_maddr];
        end
        default: ;
      endcase
    end
  end

  // Register 0 is never written, so clearing it on reset keeps it reading zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_dst] <= w_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_maddr] <= r_st_data;
  end

  assign o_alu_out   = r_alu_out;
  assign o_zero      = r_zero;
  assign o_mem_rdata = r_mem_rdata;

endmodule
